// File: rtl/accel_bus_slave.sv
// accel_bus_slave
// Accelerator-side endpoint of the CPU accelerator bus. Decodes bus reads and
// writes into an 8-entry register bank (CTRL, STATUS, SRC, DST, LEN, CFG,
// RESULT, CYCLES). It also runs the start/busy/done handshake with the
// accelerator core.
//
// Optional build macro: ACCEL_TIMEOUT_EN. When it is defined, a run that stays
// BUSY for TIMEOUT_CYCLES cycles is aborted. When it is undefined, core_abort
// is tied low and BUSY waits for core_done indefinitely.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   bus_accel_en      bus select; accesses are ignored while low
//   bus_accel_start   single-cycle start request from the CPU
//   bus_rdwr          {read, write}: 2'b01 = write, 2'b10 = read
//   bus_accregaddr    register index 0..7
//   bus_data          shared tristate data bus (read data is combinational)
//   bus_accel_done    high while the FSM is in DONE
//   core_start        one-cycle launch pulse to the core
//   core_abort        one-cycle abort pulse (timeout build only)
//   core_src/dst/len/cfg  configuration registers 2..5
//   core_done         core completion pulse; sampled only in BUSY
//   core_result       result captured when core_done is high
module accel_bus_slave #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(4096)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_accel_en,
  input  logic              bus_accel_start,
  input  logic [1:0]        bus_rdwr,
  input  logic [2:0]        bus_accregaddr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              bus_accel_done,
  output logic              core_start,
  output logic              core_abort,
  output logic [DATA_W-1:0] core_src,
  output logic [DATA_W-1:0] core_dst,
  output logic [DATA_W-1:0] core_len,
  output logic [DATA_W-1:0] core_cfg,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_SRC    = 3'd2;
  localparam logic [2:0] A_DST    = 3'd3;
  localparam logic [2:0] A_LEN    = 3'd4;
  localparam logic [2:0] A_CFG    = 3'd5;
  localparam logic [2:0] A_RESULT = 3'd6;
  localparam logic [2:0] A_CYCLES = 3'd7;

  // Saturating run-cycle increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  logic [1:0]        state;
  logic [DATA_W-1:0] src_r;
  logic [DATA_W-1:0] dst_r;
  logic [DATA_W-1:0] len_r;
  logic [DATA_W-1:0] cfg_r;
  logic [DATA_W-1:0] result_r;
  logic [CNT_W-1:0]  cycles_r;
  logic              timeout_r;

  logic              wr_en;
  logic              rd_en;
  logic              ctrl_wr;
  logic              start_req;
  logic              clear_req;
  logic              launch_go;
  logic              cfg_locked;
  logic              tmo_hit;
  logic [DATA_W-1:0] rd_data;

  // Bus decode. 2'b11 is neither a read nor a write.
  assign wr_en     = bus_accel_en && (bus_rdwr == 2'b01);
  assign rd_en     = bus_accel_en && (bus_rdwr == 2'b10);
  assign ctrl_wr   = wr_en && (bus_accregaddr == A_CTRL);
  assign start_req = (ctrl_wr && bus_data[0]) || (bus_accel_en && bus_accel_start);
  assign clear_req = ctrl_wr && bus_data[1];

  // A start is only honoured from IDLE or DONE; start beats clear in DONE.
  assign launch_go  = start_req && ((state == S_IDLE) || (state == S_DONE));
  assign cfg_locked = (state == S_LAUNCH) || (state == S_BUSY);

`ifdef ACCEL_TIMEOUT_EN
  // Fires in the BUSY cycle whose count update reaches the limit; a
  // coincident core_done takes priority and suppresses the abort.
  assign tmo_hit = (state == S_BUSY) && !core_done &&
                   (sat_inc(cycles_r) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_r <= 1'b0;
    end else if (launch_go) begin
      timeout_r <= 1'b0;
    end else if (tmo_hit) begin
      timeout_r <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit   = 1'b0;
  assign timeout_r = 1'b0;
`endif

  // Control FSM, run-cycle counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cycles_r <= '0;
      result_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch_go) begin
            state    <= S_LAUNCH;
            cycles_r <= '0;
          end
        end
        S_LAUNCH: begin
          state <= S_BUSY;
        end
        S_BUSY: begin
          cycles_r <= sat_inc(cycles_r);
          if (core_done) begin
            result_r <= core_result;
            state    <= S_DONE;
          end else if (tmo_hit) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (launch_go) begin
            state    <= S_LAUNCH;
            cycles_r <= '0;
          end else if (clear_req) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Configuration registers; frozen while a run is being launched or is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      cfg_r <= '0;
    end else if (wr_en && !cfg_locked) begin
      case (bus_accregaddr)
        A_SRC:   src_r <= bus_data;
        A_DST:   dst_r <= bus_data;
        A_LEN:   len_r <= bus_data;
        A_CFG:   cfg_r <= bus_data;
        default: ;
      endcase
    end
  end

  // Read mux works from pre-edge state, so STATUS reads never see the
  // transition happening at the same edge.
  always_comb begin
    rd_data = '0;
    case (bus_accregaddr)
      A_CTRL:   rd_data = '0;
      A_STATUS: begin
        rd_data[0] = cfg_locked;
        rd_data[1] = (state == S_DONE);
        rd_data[2] = timeout_r;
      end
      A_SRC:    rd_data = src_r;
      A_DST:    rd_data = dst_r;
      A_LEN:    rd_data = len_r;
      A_CFG:    rd_data = cfg_r;
      A_RESULT: rd_data = result_r;
      A_CYCLES: rd_data = DATA_W'(cycles_r);
      default:  rd_data = '0;
    endcase
  end

  assign bus_data       = rd_en ? rd_data : {DATA_W{1'bz}};
  assign bus_accel_done = (state == S_DONE);
  assign core_start     = (state == S_LAUNCH);
  assign core_abort     = tmo_hit;
  assign core_src       = src_r;
  assign core_dst       = dst_r;
  assign core_len       = len_r;
  assign core_cfg       = cfg_r;

endmodule

// File: doc/accel_bus_slave.md
Name: accel_bus_slave

Overview:
- Accelerator-side endpoint of the CPU accelerator bus, directly downstream of the CPU mem/wb stage.
- Decodes bus_rdwr, bus_accregaddr and bus_data into an 8-entry register bank that holds accelerator configuration and status.
- Runs the start/busy/done handshake with the accelerator datapath core.
- Drives bus_accel_done back to the CPU and supplies read data on the shared tristate bus.

Parameters:
- DATA_W, 16, bus and register width.
- CNT_W, 16, width of the run-cycle counter (saturating).
- TIMEOUT_CYCLES, 16'd4096, BUSY cycles before abort; used only with ACCEL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- bus_accel_en  in  1  bus select; when low, all bus accesses are ignored and bus_data is not driven
- bus_accel_start  in  1  single-cycle start request from CPU
- bus_rdwr  in  2  {read, write}; 2'b01 = write, 2'b10 = read
- bus_accregaddr  in  3  register index
- bus_data  inout  DATA_W  shared data bus
- bus_accel_done  out  1  high while in DONE state
- core_start  out  1  one-cycle launch pulse to core
- core_abort  out  1  one-cycle abort pulse (timeout build only)
- core_src  out  DATA_W  REG2 value
- core_dst  out  DATA_W  REG3 value
- core_len  out  DATA_W  REG4 value
- core_cfg  out  DATA_W  REG5 value
- core_done  in  1  core completion pulse
- core_result  in  DATA_W  result, sampled when core_done is high

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE; all registers clear to 0.
  - bus_accel_done, core_start and core_abort are 0; bus_data is hi-Z.
  - Reset during BUSY abandons the run with no abort pulse.
- Register map:
  - 0 CTRL: write-only. Bit0 = start. Bit1 = clear. Reads return 0.
  - 1 STATUS: read-only. Bit0 = busy, bit1 = done, bit2 = timeout; other bits 0.
  - 2 SRC, 3 DST, 4 LEN, 5 CFG: read/write.
  - 6 RESULT: read-only.
  - 7 CYCLES: read-only; cycle count of the last run.
- Writes:
  - Take effect at the clk edge when bus_accel_en=1 and bus_rdwr=2'b01.
  - Writes to read-only registers are dropped.
  - Writes to regs 2-5 while in LAUNCH or BUSY are dropped (configuration is locked).
- Reads:
  - Combinational: with bus_accel_en=1 and bus_rdwr=2'b10, bus_data = reg[bus_accregaddr] in the same cycle (zero latency, matching CPU same-cycle writeback).
  - bus_data is hi-Z otherwise.
- bus_rdwr=2'b11 is illegal: no write, bus_data not driven.
- FSM states and transitions:
  - IDLE -> LAUNCH on a start, i.e. a CTRL write with bit0=1, or bus_accel_start=1 with bus_accel_en=1. On entry: CYCLES and the timeout flag clear.
  - LAUNCH: core_start=1 for exactly one cycle, then -> BUSY.
  - BUSY: CYCLES increments each cycle, saturating at all-ones. On core_done=1: RESULT <= core_result, -> DONE.
  - DONE: bus_accel_done=1.
    - CTRL bit1 write -> IDLE.
    - A start request goes straight to LAUNCH, which also clears done.
- A start in LAUNCH or BUSY is ignored.
- core_done outside BUSY is ignored.
- A CTRL write with bit0 and bit1 both set in DONE counts as a start; start wins.
- Simultaneous read of STATUS and a state change returns the pre-edge state.
- core_done arriving in the same cycle BUSY is entered from LAUNCH is not possible. The core must wait at least one cycle after core_start; it is sampled from the first BUSY cycle onward.

Optional Feature:
- Macro: ACCEL_TIMEOUT_EN.
- Defined:
  - In BUSY, when CYCLES reaches TIMEOUT_CYCLES without core_done: core_abort pulses for one cycle, STATUS.timeout=1, RESULT is left unchanged, FSM -> DONE.
  - If core_done coincides with the timeout cycle, done wins and no abort is issued.
- Undefined: core_abort is tied to 0, STATUS bit2 reads 0, and BUSY waits indefinitely.

Test Plan:
- Reset, then read all 8 regs -> every read returns 16'h0000; bus_accel_done=0; bus_data hi-Z when bus_rdwr=2'b00.
- Write SRC=16'h1234, LEN=16'h0010, then read both -> same-cycle bus_data 16'h1234 and 16'h0010; write 16'hBEEF to RESULT -> read still 16'h0000.
- Write CTRL=16'h0001; core_done after 5 BUSY cycles with core_result=16'hA5A5 -> exactly one core_start pulse; RESULT=16'hA5A5; CYCLES=5; STATUS=16'h0002; bus_accel_done=1 until CTRL=16'h0002 is written, then 0.
- During BUSY, write SRC=16'hFFFF and pulse bus_accel_start -> SRC unchanged, no second core_start; bus_accel_en=0 with a write to CFG -> CFG unchanged.
- Assert rst mid-BUSY, then core_done -> state IDLE, done stays 0, no RESULT update; bus_rdwr=2'b11 -> bus_data hi-Z.
- ACCEL_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no core_done -> core_abort pulses once at BUSY cycle 8; STATUS=16'h0006; RESULT unchanged.
